// File: rtl/axi_calc_engine_pkg.sv
// Shared types and constants for the AXI4-Lite calculator engine.
package calc_pkg;

    // Operation codes carried in CTRL[2:0]
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MUL = 3'd5,
        OP_DIV = 3'd6,
        OP_BAD = 3'd7
    } opcode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Register word indices
    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RES_LO = 3'd4;
    localparam logic [2:0] REG_RES_HI = 3'd5;
    localparam logic [2:0] REG_CYCLES = 3'd6;
    localparam logic [2:0] REG_RSVD   = 3'd7;

    // Bit positions inside CTRL / STATUS
    localparam int CTRL_IRQ_EN_BIT = 4;
    localparam int STATUS_DONE_BIT = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Operations that run through the iterative unit
    function automatic logic is_seq_op(input opcode_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/axi_calc_engine_if.sv
// AXI4-Lite bus bundle used between the interconnect and the calculator engine.
interface axi_calc_engine_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                        awprot;
    logic                              awvalid;
    logic                              awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic [1:0]                        bresp;
    logic                              bvalid;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                        arprot;
    logic                              arvalid;
    logic                              arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                        rresp;
    logic                              rvalid;
    logic                              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_calc_engine_seq.sv
// Iterative shift-add multiplier and restoring divider sharing one counter.
// Both algorithms keep a double-width working value in hi_q:lo_q and run
// exactly DATA_W iterations; done is high during the final iteration cycle.
module calc_seq_unit
    import calc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic              run_q;
    logic [DATA_W-1:0] cnt_q;
    logic              is_div_q;
    logic [DATA_W-1:0] m_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_n;
    logic [DATA_W-1:0] lo_n;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;

    assign done = run_q && (cnt_q == DATA_W'(DATA_W - 1));
    assign hi   = hi_q;
    assign lo   = lo_q;

    // One iteration step of whichever algorithm is loaded
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[DATA_W-1]};
        div_trial = div_shift - {1'b0, m_q};
        hi_n      = hi_q;
        lo_n      = lo_q;
        if (is_div_q) begin
            if (!div_trial[DATA_W]) begin
                hi_n = div_trial[DATA_W-1:0];
                lo_n = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
                hi_n = div_shift[DATA_W-1:0];
                lo_n = {lo_q[DATA_W-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[DATA_W:1];
            lo_n = {mul_sum[0], lo_q[DATA_W-1:1]};
        end
    end

    // Iteration control: run flag and shared iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            if (done) begin
                run_q <= 1'b0;
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Working datapath: load operands on start, step while running
    always_ff @(posedge clk) begin
        if (start) begin
            is_div_q <= (op == OP_DIV);
            m_q      <= (op == OP_DIV) ? b : a;
            hi_q     <= '0;
            lo_q     <= (op == OP_DIV) ? a : b;
        end else if (run_q) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

endmodule

// File: rtl/axi_calc_engine.sv
// AXI4-Lite calculator engine: channel logic, register file and sequencer.
module axi_calc_engine
    import calc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    axi_calc_engine_if.slave s_axi,
    output logic             irq
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int ADDR_MSB = C_S_AXI_ADDR_WIDTH - 1;

    logic clk;
    logic rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    // Channel state
    logic          awready_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    // Register file
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] ctrl_q;
    logic [DW-1:0] res_lo_q;
    logic [DW-1:0] res_hi_q;
    logic [DW-1:0] cyc_q;
    logic [DW-1:0] cyc_run_q;
    logic          done_q;
    logic          div0_q;
    logic          badop_q;
    logic          irq_q;

    // Sequencer
    state_e        state_q;
    state_e        state_n;
    logic          busy;
    logic          long_op;
    logic          seq_start;
    logic          seq_done;
    logic          cyc_load;
    logic          cyc_inc;
    logic          latch_done;
    logic [DW-1:0] seq_hi;
    logic [DW-1:0] seq_lo;
    opcode_e       op;

    // Decode and derived values
    logic          wr_fire;
    logic          wr_ok;
    logic          rd_fire;
    logic [2:0]    wr_idx;
    logic [2:0]    rd_idx;
    logic [1:0]    wr_resp;
    logic          start_req;
    logic          done_clr;
    logic [DW-1:0] ctrl_wr;
    logic [DW-1:0] rd_val;
    logic [DW:0]   add_ext;
    logic [DW-1:0] res_lo_n;
    logic [DW-1:0] res_hi_n;
    logic          unused_ok;

    // Byte-lane merge of a write into an existing register value
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_val;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                r[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

    assign wr_idx  = s_axi.awaddr[ADDR_MSB:ADDR_LSB];
    assign rd_idx  = s_axi.araddr[ADDR_MSB:ADDR_LSB];
    assign wr_fire = awready_q && s_axi.awvalid && s_axi.wvalid;
    assign rd_fire = arready_q && s_axi.arvalid;
    assign wr_ok   = wr_fire && (wr_resp == RESP_OKAY);
    assign busy    = (state_q != ST_IDLE);
    assign op      = opcode_e'(ctrl_q[2:0]);
    assign long_op = (op == OP_MUL) || ((op == OP_DIV) && (opb_q != '0));

    assign start_req = wr_ok && (wr_idx == REG_CTRL) &&
                       s_axi.wstrb[SW-1] && s_axi.wdata[DW-1];
    assign done_clr  = wr_ok && (wr_idx == REG_STATUS) &&
                       s_axi.wstrb[0] && s_axi.wdata[STATUS_DONE_BIT];

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign irq           = irq_q;

    // Write response: reserved word always errors, operand/control writes error while busy
    always_comb begin
        wr_resp = RESP_OKAY;
        if (wr_idx == REG_RSVD) begin
            wr_resp = RESP_SLVERR;
        end else if (busy && (wr_idx == REG_OPA || wr_idx == REG_OPB || wr_idx == REG_CTRL)) begin
            wr_resp = RESP_SLVERR;
        end
    end

    // AW/W acceptance pulse and B channel hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            awready_q <= s_axi.awvalid && s_axi.wvalid && !awready_q && !bvalid_q;
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read data mux over the current (pre-write) register values
    always_comb begin
        rd_val = '0;
        case (rd_idx)
            REG_OPA:    rd_val = opa_q;
            REG_OPB:    rd_val = opb_q;
            REG_CTRL:   rd_val = ctrl_q;
            REG_STATUS: rd_val = {{(DW-4){1'b0}}, badop_q, div0_q, done_q, busy};
            REG_RES_LO: rd_val = res_lo_q;
            REG_RES_HI: rd_val = res_hi_q;
            REG_CYCLES: rd_val = cyc_q;
            default:    rd_val = '0;
        endcase
    end

    // AR acceptance pulse and R channel hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= s_axi.arvalid && !rvalid_q && !arready_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // CTRL write value; START is a strobe and is never stored
    always_comb begin
        ctrl_wr         = apply_strb(ctrl_q, s_axi.wdata, s_axi.wstrb);
        ctrl_wr[DW-1]   = 1'b0;
    end

    // Result selection for the DONE state; invalid opcode keeps old results
    always_comb begin
        add_ext  = {1'b0, opa_q} + {1'b0, opb_q};
        res_lo_n = res_lo_q;
        res_hi_n = res_hi_q;
        case (op)
            OP_ADD: begin
                res_lo_n = add_ext[DW-1:0];
                res_hi_n = {{(DW-1){1'b0}}, add_ext[DW]};
            end
            OP_SUB: begin
                res_lo_n = opa_q - opb_q;
                res_hi_n = (opa_q < opb_q) ? '1 : '0;
            end
            OP_AND: begin
                res_lo_n = opa_q & opb_q;
                res_hi_n = '0;
            end
            OP_OR: begin
                res_lo_n = opa_q | opb_q;
                res_hi_n = '0;
            end
            OP_XOR: begin
                res_lo_n = opa_q ^ opb_q;
                res_hi_n = '0;
            end
            OP_MUL: begin
                res_lo_n = seq_lo;
                res_hi_n = seq_hi;
            end
            OP_DIV: begin
                if (opb_q == '0) begin
                    res_lo_n = '1;
                    res_hi_n = opa_q;
                end else begin
                    res_lo_n = seq_lo;
                    res_hi_n = seq_hi;
                end
            end
            default: begin
                res_lo_n = res_lo_q;
                res_hi_n = res_hi_q;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (start_req) state_n = ST_EXEC;
            ST_EXEC: state_n = long_op ? ST_ITER : ST_DONE;
            ST_ITER: if (seq_done) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Sequencer outputs decoded from the current state
    always_comb begin
        seq_start  = 1'b0;
        cyc_load   = 1'b0;
        cyc_inc    = 1'b0;
        latch_done = 1'b0;
        case (state_q)
            ST_EXEC: begin
                seq_start = long_op;
                cyc_load  = 1'b1;
            end
            ST_ITER: cyc_inc    = 1'b1;
            ST_DONE: latch_done = 1'b1;
            default: ;
        endcase
    end

    // Register file, status flags and cycle accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q     <= '0;
            opb_q     <= '0;
            ctrl_q    <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            cyc_q     <= '0;
            cyc_run_q <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            badop_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (wr_idx)
                    REG_OPA:  opa_q  <= apply_strb(opa_q, s_axi.wdata, s_axi.wstrb);
                    REG_OPB:  opb_q  <= apply_strb(opb_q, s_axi.wdata, s_axi.wstrb);
                    REG_CTRL: ctrl_q <= ctrl_wr;
                    default: ;
                endcase
            end
            if (start_req) begin
                done_q  <= 1'b0;
                div0_q  <= 1'b0;
                badop_q <= 1'b0;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
            if (cyc_load) begin
                cyc_run_q <= DW'(1);
            end else if (cyc_inc) begin
                cyc_run_q <= cyc_run_q + 1'b1;
            end
            // A completion in the same cycle as a W1C keeps done set
            if (latch_done) begin
                res_lo_q <= res_lo_n;
                res_hi_q <= res_hi_n;
                cyc_q    <= cyc_run_q;
                done_q   <= 1'b1;
                div0_q   <= (op == OP_DIV) && (opb_q == '0);
                badop_q  <= (op == OP_BAD);
            end
        end
    end

    // Interrupt register: done gated by the enable bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done_q && ctrl_q[CTRL_IRQ_EN_BIT];
        end
    end

    calc_seq_unit #(
        .DATA_W (DW)
    ) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (seq_start),
        .op    (op),
        .a     (opa_q),
        .b     (opb_q),
        .done  (seq_done),
        .hi    (seq_hi),
        .lo    (seq_lo)
    );

endmodule

// File: tb/tb_axi_calc_engine.sv
// Directed bench for the AXI4-Lite calculator engine (32-bit configuration).
module tb_axi_calc_engine;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [AW-1:0] A_OPA    = 5'h00;
    localparam logic [AW-1:0] A_OPB    = 5'h04;
    localparam logic [AW-1:0] A_CTRL   = 5'h08;
    localparam logic [AW-1:0] A_STATUS = 5'h0C;
    localparam logic [AW-1:0] A_RES_LO = 5'h10;
    localparam logic [AW-1:0] A_RES_HI = 5'h14;
    localparam logic [AW-1:0] A_CYCLES = 5'h18;
    localparam logic [AW-1:0] A_RSVD   = 5'h1C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   hs_cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    axi_calc_engine_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) bus ();

    axi_calc_engine #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .s_axi         (bus),
        .irq           (irq)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wr_accept", bus.awready & bus.wready, 1);
        tick();
        hs_cyc      = cyc;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid", bus.bvalid, 1);
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data);
        int n;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rd_accept", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("rd_rvalid", bus.rvalid, 1);
        data = bus.rdata;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                      input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
        check(tag, r, exp_resp);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_done();
        logic [31:0] s;
        int n;
        s = '0;
        n = 0;
        while (s[1] !== 1'b1 && n < 100) begin
            axi_read(A_STATUS, s);
            n++;
        end
        check("done_poll", s[1], 1);
    endtask

    task automatic wait_irq(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, cyc - hs_cyc, exp_lat);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ctrl);
        wr({tag, "_wr_opa"}, A_OPA, a, 2'b00);
        wr({tag, "_wr_opb"}, A_OPB, b, 2'b00);
        wr({tag, "_wr_ctrl"}, A_CTRL, ctrl, 2'b00);
        wait_done();
    endtask

    initial begin
        int n;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();

        // Reset state of every output
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_irq", irq, 0);
        rst_n = 1'b1;
        tick();
        rd("rst_status", A_STATUS, 32'h0);
        rd("rst_opa", A_OPA, 32'h0);
        rd("rst_res_lo", A_RES_LO, 32'h0);

        // ADD 7 + 5
        run_op("add", 32'd7, 32'd5, 32'h8000_0000);
        rd("add_status", A_STATUS, 32'h2);
        rd("add_lo", A_RES_LO, 32'd12);
        rd("add_hi", A_RES_HI, 32'd0);
        rd("add_cycles", A_CYCLES, 32'd1);
        rd("add_ctrl_start_reads0", A_CTRL, 32'h0);

        // ADD with carry out
        run_op("addc", 32'hFFFF_FFFF, 32'd2, 32'h8000_0000);
        rd("addc_lo", A_RES_LO, 32'd1);
        rd("addc_hi", A_RES_HI, 32'd1);

        // SUB with borrow
        run_op("sub", 32'd5, 32'd7, 32'h8000_0001);
        rd("sub_lo", A_RES_LO, 32'hFFFF_FFFE);
        rd("sub_hi", A_RES_HI, 32'hFFFF_FFFF);

        // AND / OR
        run_op("and", 32'h0000_F0F0, 32'h0000_FF00, 32'h8000_0002);
        rd("and_lo", A_RES_LO, 32'h0000_F000);
        rd("and_hi", A_RES_HI, 32'h0);
        run_op("or", 32'h0000_F0F0, 32'h0000_FF00, 32'h8000_0003);
        rd("or_lo", A_RES_LO, 32'h0000_FFF0);

        // MUL with irq enabled: irq one cycle after done at E+34
        wr("mul_wr_opa", A_OPA, 32'hFFFF_FFFF, 2'b00);
        wr("mul_wr_opb", A_OPB, 32'd2, 2'b00);
        wr("mul_wr_ctrl", A_CTRL, 32'h8000_0015, 2'b00);
        wait_irq("mul_irq_latency", 35);
        rd("mul_status", A_STATUS, 32'h2);
        rd("mul_hi", A_RES_HI, 32'd1);
        rd("mul_lo", A_RES_LO, 32'hFFFF_FFFE);
        rd("mul_cycles", A_CYCLES, 32'd33);

        // MUL again: busy visible, operand and START writes rejected
        wr("mul2_wr_ctrl", A_CTRL, 32'h8000_0005, 2'b00);
        rd("mul2_busy", A_STATUS, 32'h1);
        wr("mul2_opa_busy_slverr", A_OPA, 32'h0000_1234, 2'b10);
        wr("mul2_start_busy_slverr", A_CTRL, 32'h8000_0000, 2'b10);
        wait_done();
        rd("mul2_opa_unchanged", A_OPA, 32'hFFFF_FFFF);
        rd("mul2_ctrl_unchanged", A_CTRL, 32'h5);
        rd("mul2_lo", A_RES_LO, 32'hFFFF_FFFE);
        rd("mul2_status", A_STATUS, 32'h2);

        // DIV by zero
        run_op("div0", 32'd100, 32'd0, 32'h8000_0006);
        rd("div0_status", A_STATUS, 32'h6);
        rd("div0_lo", A_RES_LO, 32'hFFFF_FFFF);
        rd("div0_hi", A_RES_HI, 32'd100);
        rd("div0_cycles", A_CYCLES, 32'd1);

        // DIV 100 / 7
        wr("div_wr_opb", A_OPB, 32'd7, 2'b00);
        wr("div_wr_ctrl", A_CTRL, 32'h8000_0006, 2'b00);
        wait_done();
        rd("div_status", A_STATUS, 32'h2);
        rd("div_lo", A_RES_LO, 32'd14);
        rd("div_hi", A_RES_HI, 32'd2);
        rd("div_cycles", A_CYCLES, 32'd33);

        // Reserved word and read-only register writes
        wr("rsvd_slverr", A_RSVD, 32'h1234_5678, 2'b10);
        wr("res_lo_ro_okay", A_RES_LO, 32'h0000_DEAD, 2'b00);
        rd("res_lo_unchanged", A_RES_LO, 32'd14);
        rd("rsvd_reads0", A_RSVD, 32'h0);

        // Invalid opcode: done + badop, results kept
        wr("bad_wr_ctrl", A_CTRL, 32'h8000_0007, 2'b00);
        wait_done();
        rd("bad_status", A_STATUS, 32'hA);
        rd("bad_lo_kept", A_RES_LO, 32'd14);
        rd("bad_hi_kept", A_RES_HI, 32'd2);

        // XOR with irq, then W1C on done
        wr("xor_wr_opa", A_OPA, 32'h0000_F0F0, 2'b00);
        wr("xor_wr_opb", A_OPB, 32'h0000_FF00, 2'b00);
        wr("xor_wr_ctrl", A_CTRL, 32'h8000_0014, 2'b00);
        wait_irq("xor_irq_latency", 3);
        rd("xor_lo", A_RES_LO, 32'h0000_0FF0);
        rd("xor_ctrl", A_CTRL, 32'h14);
        wr("xor_w1c", A_STATUS, 32'h2, 2'b00);
        check("xor_irq_dropped", irq, 0);
        rd("xor_status_cleared", A_STATUS, 32'h0);

        // W before AW, narrow strobe, BREADY held off
        bus.wdata  = 32'hAABB_CCDD;
        bus.wstrb  = 4'h1;
        bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        repeat (5) tick();
        check("late_aw_no_accept", bus.wready, 0);
        bus.awaddr  = A_OPA;
        bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("late_aw_accept", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("bhold_valid0", bus.bvalid, 1);
        repeat (3) tick();
        check("bhold_valid3", bus.bvalid, 1);
        check("bhold_resp", bus.bresp, 0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("bhold_released", bus.bvalid, 0);
        tick();
        check("bhold_single", bus.bvalid, 0);
        rd("strb_opa", A_OPA, 32'h0000_F0DD);

        // Reset during DIV with a read response pending
        wr("rstdiv_wr_opa", A_OPA, 32'd100, 2'b00);
        wr("rstdiv_wr_ctrl", A_CTRL, 32'h8000_0016, 2'b00);
        bus.araddr  = A_STATUS;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.arvalid = 1'b0;
        check("rstdiv_r_pending", bus.rvalid, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstdiv_rvalid", bus.rvalid, 0);
        check("rstdiv_rdata", bus.rdata, 0);
        check("rstdiv_arready", bus.arready, 0);
        check("rstdiv_awready", bus.awready, 0);
        check("rstdiv_bvalid", bus.bvalid, 0);
        check("rstdiv_irq", irq, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rd("rstdiv_status", A_STATUS, 32'h0);
        rd("rstdiv_opa", A_OPA, 32'h0);
        rd("rstdiv_ctrl", A_CTRL, 32'h0);
        rd("rstdiv_res_lo", A_RES_LO, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
